// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types and constants for the March C- RAM BIST controller.
//   bist_state_t   controller state encoding
//   march_elem_t   one march element: direction, read/expect, write/value
//   march_elem()   the M0-M5 element table, indexed by element number
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ONLY  = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_CHK   = 3'd3,
        ST_DONE     = 3'd4
    } bist_state_t;

    // Values are 1-bit backgrounds; they are replicated across the data width.
    typedef struct packed {
        logic down;
        logic rd_en;
        logic rd_val;
        logic wr_en;
        logic wr_val;
    } march_elem_t;

    localparam int         NUM_ELEM = 6;
    localparam logic [7:0] ZERO_BG  = 8'h00;
    localparam logic [7:0] ONE_BG   = 8'hFF;

    // Bit order: {down, rd_en, rd_val, wr_en, wr_val}
    function automatic march_elem_t march_elem(input logic [2:0] idx);
        case (idx)
            3'd0:    march_elem = march_elem_t'(5'b0_0_0_1_0); // up   (w0)
            3'd1:    march_elem = march_elem_t'(5'b0_1_0_1_1); // up   (r0,w1)
            3'd2:    march_elem = march_elem_t'(5'b0_1_1_1_0); // up   (r1,w0)
            3'd3:    march_elem = march_elem_t'(5'b1_1_0_1_1); // down (r0,w1)
            3'd4:    march_elem = march_elem_t'(5'b1_1_1_1_0); // down (r1,w0)
            3'd5:    march_elem = march_elem_t'(5'b0_1_0_0_0); // up   (r0)
            default: march_elem = march_elem_t'(5'b0);
        endcase
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// bist_addr_gen: loadable up/down address counter for the march elements.
//   clk, rst    clock, synchronous active-high reset
//   load        load the first address of the direction given by load_down
//   load_down   1: load all-ones (descending), 0: load zero (ascending)
//   step        advance one address in the direction given by down
//   down        direction of the element currently running
//   addr        current address
//   first/last  addr is the first/last address for direction down
module bist_addr_gen #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              first,
    output logic              last
);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst)
            addr <= '0;
        else if (load)
            addr <= {ADDR_W{load_down}};
        else if (step)
            addr <= down ? addr - ONE : addr + ONE;
    end

    assign first = down ? (addr == '1) : (addr == '0);
    assign last  = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: March C- BIST controller for a dual-address RAM.
//   ram_clk, ram_rst          clock, synchronous active-high reset
//   bist_start                one-cycle start request (ignored while busy)
//   ram_rd_dat                RAM read data, one cycle after ram_rd_addrs
//   ram_rd_addrs              RAM read address
//   ram_wrt_addrs/_en/_dat    RAM write port
//   bist_busy, bist_done      test running / finished (done sticky)
//   bist_fail, fail_addr,     sticky fail flag and first-miscompare
//   fail_elem, fail_data      location, element and read data
//   err_cnt                   saturating miscompare count
// Build option: BIST_STOP_ON_FAIL_EN ends the test on the first miscompare
// and suppresses that cycle's write.
//
// state       | meaning
// ST_IDLE     | waiting for bist_start
// ST_WR_ONLY  | write-only element (M0), one write per cycle
// ST_RD_ISSUE | read address presented to RAM
// ST_RD_CHK   | read data compared; write of same address if element writes
// ST_DONE     | test complete, results held until next start
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              ram_clk,
    input  logic              ram_rst,
    input  logic              bist_start,
    input  logic [DATA_W-1:0] ram_rd_dat,
    output logic [ADDR_W-1:0] ram_rd_addrs,
    output logic [ADDR_W-1:0] ram_wrt_addrs,
    output logic              ram_wrt_en,
    output logic [DATA_W-1:0] ram_wrt_dat,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_data,
    output logic [15:0]       err_cnt
);
    bist_state_t       state, state_nxt;
    logic [2:0]        elem;
    march_elem_t       cur, nxt;
    logic [ADDR_W-1:0] addr;
    logic              addr_last, addr_first_unused;
    logic              start_ok, final_elem, miscmp, abort, adv;
    logic              ag_load, ag_load_down, ag_step;

    assign start_ok   = bist_start && (state == ST_IDLE || state == ST_DONE);
    assign final_elem = (elem == 3'(NUM_ELEM - 1));
    assign cur        = march_elem(elem);
    assign nxt        = march_elem(final_elem ? elem : elem + 3'd1);
    assign miscmp     = (state == ST_RD_CHK) && cur.rd_en &&
                        (ram_rd_dat != {DATA_W{cur.rd_val}});
`ifdef BIST_STOP_ON_FAIL_EN
    assign abort = miscmp;
`else
    assign abort = 1'b0;
`endif
    // adv: the current address is finished this cycle
    assign adv          = (state == ST_WR_ONLY) || (state == ST_RD_CHK && !abort);
    assign ag_load      = start_ok || (adv && addr_last && !final_elem);
    assign ag_load_down = start_ok ? march_elem(3'd0).down : nxt.down;
    assign ag_step      = adv && !addr_last;

    bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (ram_clk),
        .rst       (ram_rst),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (cur.down),
        .addr      (addr),
        .first     (addr_first_unused),
        .last      (addr_last)
    );

    always_ff @(posedge ram_clk) begin
        if (ram_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE:
                if (start_ok)
                    state_nxt = march_elem(3'd0).rd_en ? ST_RD_ISSUE : ST_WR_ONLY;
            ST_WR_ONLY:
                if (addr_last)
                    state_nxt = final_elem ? ST_DONE :
                                (nxt.rd_en ? ST_RD_ISSUE : ST_WR_ONLY);
            ST_RD_ISSUE:
                state_nxt = ST_RD_CHK;
            ST_RD_CHK:
                if (abort)
                    state_nxt = ST_DONE;
                else if (addr_last)
                    state_nxt = final_elem ? ST_DONE :
                                (nxt.rd_en ? ST_RD_ISSUE : ST_WR_ONLY);
                else
                    state_nxt = ST_RD_ISSUE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bist_busy     = (state == ST_WR_ONLY) || (state == ST_RD_ISSUE) ||
                        (state == ST_RD_CHK);
        bist_done     = (state == ST_DONE);
        ram_wrt_en    = (state == ST_WR_ONLY) ||
                        ((state == ST_RD_CHK) && cur.wr_en && !abort);
        ram_wrt_dat   = ram_wrt_en ? {DATA_W{cur.wr_val}} : '0;
        ram_wrt_addrs = addr;
        ram_rd_addrs  = addr;
    end

    always_ff @(posedge ram_clk) begin
        if (ram_rst || start_ok)
            elem <= 3'd0;
        else if (adv && addr_last && !final_elem)
            elem <= elem + 3'd1;
    end

    always_ff @(posedge ram_clk) begin
        if (ram_rst || start_ok) begin
            bist_fail <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 3'd0;
            fail_data <= '0;
            err_cnt   <= 16'h0000;
        end else if (miscmp) begin
            if (err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'h0001;
            if (!bist_fail) begin
                bist_fail <= 1'b1;
                fail_addr <= addr;
                fail_elem <= elem;
                fail_data <= ram_rd_dat;
            end
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: bench for ram_bist_ctrl with a 1024x8 RAM model and
// injectable read faults. Expected test outcomes are queued at each start
// and compared when the controller reports done.
module tb_ram_bist_ctrl;

`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       ram_clk = 1'b0;
    logic       ram_rst = 1'b1;
    logic       bist_start = 1'b0;
    logic [7:0] ram_rd_dat;
    logic [9:0] ram_rd_addrs, ram_wrt_addrs, fail_addr;
    logic       ram_wrt_en, bist_busy, bist_done, bist_fail;
    logic [7:0] ram_wrt_dat, fail_data;
    logic [2:0] fail_elem;
    logic [15:0] err_cnt;

    always #5 ram_clk = ~ram_clk;

    ram_bist_ctrl #(.ADDR_W(10), .DATA_W(8)) dut (
        .ram_clk       (ram_clk),
        .ram_rst       (ram_rst),
        .bist_start    (bist_start),
        .ram_rd_dat    (ram_rd_dat),
        .ram_rd_addrs  (ram_rd_addrs),
        .ram_wrt_addrs (ram_wrt_addrs),
        .ram_wrt_en    (ram_wrt_en),
        .ram_wrt_dat   (ram_wrt_dat),
        .bist_busy     (bist_busy),
        .bist_done     (bist_done),
        .bist_fail     (bist_fail),
        .fail_addr     (fail_addr),
        .fail_elem     (fail_elem),
        .fail_data     (fail_data),
        .err_cnt       (err_cnt)
    );

    // RAM model: synchronous write, registered read.
    // fault_mode 1: bit 3 of 0x155 stuck-at-0; 2: 0x3FF stuck at 0xFF.
    logic [7:0] mem [1024];
    logic [7:0] rd_q;
    logic [9:0] ra_q;
    int         fault_mode = 0;
    int         wr_total = 0;

    always @(posedge ram_clk) begin
        if (ram_wrt_en) begin
            mem[ram_wrt_addrs] <= ram_wrt_dat;
            wr_total <= wr_total + 1;
        end
        rd_q <= mem[ram_rd_addrs];
        ra_q <= ram_rd_addrs;
    end

    assign ram_rd_dat = (fault_mode == 1 && ra_q == 10'h155) ? (rd_q & 8'hF7) :
                        (fault_mode == 2 && ra_q == 10'h3FF) ? 8'hFF : rd_q;

    typedef struct {
        string       name;
        int          lat;
        logic        fail;
        logic [9:0]  addr;
        logic [2:0]  elem;
        logic [7:0]  data;
        logic [15:0] err;
        int          wr;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(bist_busy), 0);
        check({tag, "_done"},  32'(bist_done), 0);
        check({tag, "_fail"},  32'(bist_fail), 0);
        check({tag, "_err"},   32'(err_cnt), 0);
        check({tag, "_faddr"}, 32'(fail_addr), 0);
        check({tag, "_felem"}, 32'(fail_elem), 0);
        check({tag, "_fdata"}, 32'(fail_data), 0);
        check({tag, "_wen"},   32'(ram_wrt_en), 0);
        check({tag, "_waddr"}, 32'(ram_wrt_addrs), 0);
        check({tag, "_raddr"}, 32'(ram_rd_addrs), 0);
    endtask

    // k counts cycles after the start edge: sample k sees the value the DUT
    // presents going into edge N+k.
    task automatic run_test(input string name, input int fm, input int repulse_k,
                            input bit probe, input int lat, input logic fail,
                            input logic [9:0] faddr, input logic [2:0] felem,
                            input logic [7:0] fdata, input logic [15:0] err,
                            input int wr);
        exp_t e, got;
        int   k, wr_base;
        e.name = name; e.lat = lat; e.fail = fail; e.addr = faddr;
        e.elem = felem; e.data = fdata; e.err = err; e.wr = wr;
        sb.push_back(e);
        fault_mode = fm;
        @(negedge ram_clk);
        wr_base = wr_total;
        bist_start = 1'b1;
        @(negedge ram_clk);
        bist_start = 1'b0;
        k = 1;
        check({name, "_busy_k1"},   32'(bist_busy), 1);
        check({name, "_clr_fail"},  32'(bist_fail), 0);
        check({name, "_clr_err"},   32'(err_cnt), 0);
        check({name, "_clr_done"},  32'(bist_done), 0);
        while (!bist_done && k < 20000) begin
            @(negedge ram_clk);
            k++;
            bist_start = (k == repulse_k);
            if (probe && k == 1025) check({name, "_m1_first"}, 32'(ram_rd_addrs), 32'h000);
            if (probe && k == 5121) check({name, "_m3_first"}, 32'(ram_rd_addrs), 32'h3FF);
            if (probe && k == 5122) begin
                check({name, "_m3_wen"},  32'(ram_wrt_en), 1);
                check({name, "_m3_wadr"}, 32'(ram_wrt_addrs), 32'h3FF);
                check({name, "_m3_wdat"}, 32'(ram_wrt_dat), 32'hFF);
            end
        end
        bist_start = 1'b0;
        got = sb.pop_front();
        check({got.name, "_latency"}, 32'(k), 32'(got.lat));
        check({got.name, "_done"},    32'(bist_done), 1);
        check({got.name, "_busy"},    32'(bist_busy), 0);
        check({got.name, "_fail"},    32'(bist_fail), 32'(got.fail));
        check({got.name, "_faddr"},   32'(fail_addr), 32'(got.addr));
        check({got.name, "_felem"},   32'(fail_elem), 32'(got.elem));
        check({got.name, "_fdata"},   32'(fail_data), 32'(got.data));
        check({got.name, "_err"},     32'(err_cnt), 32'(got.err));
        check({got.name, "_writes"},  32'(wr_total - wr_base), 32'(got.wr));
        check({got.name, "_wen_done"}, 32'(ram_wrt_en), 0);
    endtask

    initial begin
        int nz, k;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h5A;
        repeat (3) @(negedge ram_clk);
        ram_rst = 1'b0;
        check_idle_outputs("reset");

        // clean run, with a start pulse while busy that must be ignored
        run_test("clean", 0, 500, 1'b1, 11265, 1'b0, 10'h000, 3'd0, 8'h00, 16'd0, 5120);
        nz = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] != 8'h00) nz++;
        check("clean_mem_zero", 32'(nz), 0);

        run_test("sa0_155", 1, 0, 1'b0, STOP ? 3757 : 11265, 1'b1, 10'h155, 3'd2,
                 8'hF7, STOP ? 16'd1 : 16'd2, STOP ? 2389 : 5120);
        check("sa0_155_mem", 32'(mem[10'h155]), STOP ? 32'hFF : 32'h00);

        // restart after done clears the previous failure
        run_test("rerun", 0, 0, 1'b0, 11265, 1'b0, 10'h000, 3'd0, 8'h00, 16'd0, 5120);

        run_test("sff_3ff", 2, 0, 1'b0, STOP ? 3073 : 11265, 1'b1, 10'h3FF, 3'd1,
                 8'hFF, STOP ? 16'd1 : 16'd3, STOP ? 2047 : 5120);

        // reset in the middle of M3
        fault_mode = 0;
        @(negedge ram_clk);
        bist_start = 1'b1;
        @(negedge ram_clk);
        bist_start = 1'b0;
        k = 1;
        while (k < 6000) begin
            @(negedge ram_clk);
            k++;
        end
        check("mid_m3_busy", 32'(bist_busy), 1);
        ram_rst = 1'b1;
        @(negedge ram_clk);
        ram_rst = 1'b0;
        check_idle_outputs("mid_rst");
        run_test("post_rst", 0, 0, 1'b0, 11265, 1'b0, 10'h000, 3'd0, 8'h00, 16'd0, 5120);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
